// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if
//   Bundles every bus signal around axi_read_arbiter: the two requester
//   ports (fetch F_*, load D_*), the single-beat AXI4 read master channel
//   (M_AXI_AR*, M_AXI_R*) and the BUSY status flag.
//
//   Modports:
//     master - the arbiter's view. It drives F/D GNT, RVALID, RDATA and RERR,
//              the AR channel, RREADY and BUSY.
//     slave  - the environment's view. This covers the requesters and the
//              AXI slave, which drive REQ/ADDR and the AXI responses.
//
//   M_AXI_RID is not carried because routing uses the latched owner.
interface axi_read_arbiter_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  logic                          F_REQ;
  logic [C_M_AXI_ADDR_WIDTH-1:0] F_ADDR;
  logic                          F_GNT;
  logic                          F_RVALID;
  logic [C_M_AXI_DATA_WIDTH-1:0] F_RDATA;
  logic                          F_RERR;

  logic                          D_REQ;
  logic [C_M_AXI_ADDR_WIDTH-1:0] D_ADDR;
  logic                          D_GNT;
  logic                          D_RVALID;
  logic [C_M_AXI_DATA_WIDTH-1:0] D_RDATA;
  logic                          D_RERR;

  logic                          M_AXI_ARID;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [7:0]                    M_AXI_ARLEN;
  logic [2:0]                    M_AXI_ARSIZE;
  logic [1:0]                    M_AXI_ARBURST;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RLAST;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  logic                          BUSY;

  modport master (
    input  F_REQ, F_ADDR, D_REQ, D_ADDR,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output F_GNT, F_RVALID, F_RDATA, F_RERR,
    output D_GNT, D_RVALID, D_RDATA, D_RERR,
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARVALID, M_AXI_RREADY, BUSY
  );

  modport slave (
    output F_REQ, F_ADDR, D_REQ, D_ADDR,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  F_GNT, F_RVALID, F_RDATA, F_RERR,
    input  D_GNT, D_RVALID, D_RDATA, D_RERR,
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARVALID, M_AXI_RREADY, BUSY
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//   Shares the core's AXI4 read channel between instruction fetch (F) and
//   data load (D). It issues one single-beat 32-bit read at a time. Arbitration
//   is round-robin (PRIORITY_MODE=0) or fixed F-over-D priority
//   (PRIORITY_MODE=1). The response is returned to the requester that owns
//   the transaction.
//
//   Ports:
//     ACLK    - clock
//     ARESETN - asynchronous active-low reset
//     bus     - axi_read_arbiter_if.master, which carries these groups:
//               the requester ports F_*/D_* (REQ, ADDR, GNT, RVALID,
//               RDATA, RERR), the AXI AR/R master channel and BUSY.
//
//   All outputs are registered.
module axi_read_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int PRIORITY_MODE      = 0
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  axi_read_arbiter_if.master bus
);
  localparam int  AW         = C_M_AXI_ADDR_WIDTH;
  localparam int  DW         = C_M_AXI_DATA_WIDTH;
  localparam bit  FIXED_PRIO = (PRIORITY_MODE != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            arvalid_q, arvalid_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic            arid_q, arid_d;
  logic            rready_q, rready_d;
  logic            busy_q, busy_d;
  logic            last_owner_q, last_owner_d;
  logic            f_gnt_q, f_gnt_d;
  logic            d_gnt_q, d_gnt_d;
  logic            f_rvalid_q, f_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            f_rerr_q, f_rerr_d;
  logic            d_rerr_q, d_rerr_d;

  logic            ar_hs;
  logic            r_last_hs;
  logic            pick_d;
  logic            unused_rresp0;

  // Only RRESP[1] encodes an error (SLVERR/DECERR). Bit 0 is not needed.
  assign unused_rresp0 = bus.M_AXI_RRESP[0];

  assign ar_hs     = arvalid_q & bus.M_AXI_ARREADY;
  assign r_last_hs = rready_q & bus.M_AXI_RVALID & bus.M_AXI_RLAST;

  // D wins when it asks alone. In round-robin mode it also wins a tie
  // when F owned the previous transaction (last_owner_q == 0).
  assign pick_d = bus.D_REQ & (~bus.F_REQ | (~FIXED_PRIO & ~last_owner_q));

  always_comb begin
    state_d      = state_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arid_d       = arid_q;
    rready_d     = rready_q;
    busy_d       = busy_q;
    last_owner_d = last_owner_q;
    f_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    f_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    f_rerr_d     = f_rerr_q;
    d_rerr_d     = d_rerr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.F_REQ || bus.D_REQ) begin
          state_d      = ADDR;
          arvalid_d    = 1'b1;
          busy_d       = 1'b1;
          arid_d       = pick_d;
          last_owner_d = pick_d;
          araddr_d     = pick_d ? bus.D_ADDR : bus.F_ADDR;
          f_gnt_d      = ~pick_d;
          d_gnt_d      = pick_d;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          state_d   = DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      DATA: begin
        // Non-last beats are accepted and dropped. Only the RLAST beat is
        // delivered, straight into the owner's output registers.
        if (r_last_hs) begin
          state_d  = IDLE;
          rready_d = 1'b0;
          busy_d   = 1'b0;
          if (arid_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = bus.M_AXI_RDATA;
            d_rerr_d   = bus.M_AXI_RRESP[1];
          end else begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = bus.M_AXI_RDATA;
            f_rerr_d   = bus.M_AXI_RRESP[1];
          end
        end
      end
      default: begin
        state_d   = IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Reset leaves last_owner at D, so F wins the first tie.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arid_q       <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
      last_owner_q <= 1'b1;
      f_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      f_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      f_rerr_q     <= 1'b0;
      d_rerr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arid_q       <= arid_d;
      rready_q     <= rready_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
      f_gnt_q      <= f_gnt_d;
      d_gnt_q      <= d_gnt_d;
      f_rvalid_q   <= f_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      f_rerr_q     <= f_rerr_d;
      d_rerr_q     <= d_rerr_d;
    end
  end

  assign bus.F_GNT         = f_gnt_q;
  assign bus.D_GNT         = d_gnt_q;
  assign bus.F_RVALID      = f_rvalid_q;
  assign bus.D_RVALID      = d_rvalid_q;
  assign bus.F_RDATA       = f_rdata_q;
  assign bus.D_RDATA       = d_rdata_q;
  assign bus.F_RERR        = f_rerr_q;
  assign bus.D_RERR        = d_rerr_q;
  assign bus.M_AXI_ARID    = arid_q;
  assign bus.M_AXI_ARADDR  = araddr_q;
  assign bus.M_AXI_ARLEN   = 8'd0;
  assign bus.M_AXI_ARSIZE  = 3'b010;
  assign bus.M_AXI_ARBURST = 2'b01;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;
  assign bus.BUSY          = busy_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
//   Scoreboard bench for axi_read_arbiter. There are two instances:
//     rr - round-robin, driven by a programmable AXI slave process
//     fp - fixed priority, with an always-ready slave that echoes ARADDR
//   Stimulus pushes the expected grants and responses into queues.
//   Independent monitors pop and compare whenever the DUT pulses a grant or
//   a response.
module tb_axi_read_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  axi_read_arbiter_if #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) rr ();
  axi_read_arbiter_if #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) fp ();

  axi_read_arbiter #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .PRIORITY_MODE(0))
    dut_rr (.ACLK(clk), .ARESETN(rst_n), .bus(rr));
  axi_read_arbiter #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .PRIORITY_MODE(1))
    dut_fp (.ACLK(clk), .ARESETN(rst_n), .bus(fp));

  typedef struct {logic owner; logic [31:0] addr;} gnt_t;
  typedef struct {logic owner; logic [31:0] data; logic err;} rsp_t;

  gnt_t rr_gnt_q[$];
  rsp_t rr_rsp_q[$];
  gnt_t fp_gnt_q[$];
  rsp_t fp_rsp_q[$];

  int compared = 0;
  int mismatched = 0;

  // Configuration of the round-robin side's AXI slave
  int          slv_ar_wait = 0;
  int          slv_r_wait = 0;
  int          slv_pre = 0;
  logic [31:0] slv_data = '0;
  logic [31:0] slv_pre_data = '0;
  logic [1:0]  slv_resp = '0;
  logic [1:0]  slv_pre_resp = '0;

  // Fixed-priority slave: always ready, single-beat response derived from ARADDR
  assign fp.M_AXI_ARREADY = 1'b1;
  assign fp.M_AXI_RVALID  = 1'b1;
  assign fp.M_AXI_RLAST   = 1'b1;
  assign fp.M_AXI_RRESP   = 2'b00;
  assign fp.M_AXI_RDATA   = fp.M_AXI_ARADDR ^ 32'hA5A5_0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a lone rr request and wait for its grant. Returns the number of
  // cycles from REQ to GNT.
  task automatic applyStimulus(input logic owner, input logic [31:0] addr,
                               input logic [31:0] data, input logic [1:0] resp,
                               input bit expect_rsp, output int gnt_lat);
    rr_gnt_q.push_back(gnt_t'{owner: owner, addr: addr});
    if (expect_rsp) rr_rsp_q.push_back(rsp_t'{owner: owner, data: data, err: resp[1]});
    slv_data = data;
    slv_resp = resp;
    if (owner) begin rr.D_ADDR = addr; rr.D_REQ = 1'b1; end
    else       begin rr.F_ADDR = addr; rr.F_REQ = 1'b1; end
    gnt_lat = 0;
    do begin @(negedge clk); gnt_lat++; end
    while (!(rr.F_GNT || rr.D_GNT) && gnt_lat < 20);
    rr.F_REQ = 1'b0;
    rr.D_REQ = 1'b0;
  endtask

  task automatic waitResponse(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end
    while (!(rr.F_RVALID || rr.D_RVALID) && lat < 60);
  endtask

  // Programmable AXI slave for the rr instance. Every wait aborts on reset.
  initial begin : rr_slave
    forever begin
      @(negedge clk);
      if (rst_n && rr.M_AXI_ARVALID) begin
        for (int i = 0; i < slv_ar_wait && rst_n; i++) @(negedge clk);
        if (rst_n) begin
          rr.M_AXI_ARREADY = 1'b1;
          @(negedge clk);
          rr.M_AXI_ARREADY = 1'b0;
        end
        for (int i = 0; i < slv_r_wait && rst_n; i++) @(negedge clk);
        for (int i = 0; i < slv_pre && rst_n; i++) begin
          rr.M_AXI_RVALID = 1'b1;
          rr.M_AXI_RLAST  = 1'b0;
          rr.M_AXI_RDATA  = slv_pre_data;
          rr.M_AXI_RRESP  = slv_pre_resp;
          @(negedge clk);
        end
        if (rst_n) begin
          rr.M_AXI_RVALID = 1'b1;
          rr.M_AXI_RLAST  = 1'b1;
          rr.M_AXI_RDATA  = slv_data;
          rr.M_AXI_RRESP  = slv_resp;
          @(negedge clk);
        end
        rr.M_AXI_ARREADY = 1'b0;
        rr.M_AXI_RVALID  = 1'b0;
        rr.M_AXI_RLAST   = 1'b0;
      end
    end
  end

  // Monitor for the rr instance
  initial begin : rr_monitor
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rr.F_GNT || rr.D_GNT) begin
          if (rr_gnt_q.size() == 0) checkOutput("rr_gnt_unexpected", 32'(rr.F_GNT | rr.D_GNT), 0);
          else begin
            g = rr_gnt_q.pop_front();
            checkOutput("rr_gnt_owner", 32'(rr.D_GNT), 32'(g.owner));
            checkOutput("rr_gnt_both", 32'(rr.F_GNT & rr.D_GNT), 0);
            checkOutput("rr_arid", 32'(rr.M_AXI_ARID), 32'(g.owner));
            checkOutput("rr_araddr", rr.M_AXI_ARADDR, g.addr);
            checkOutput("rr_arvalid_at_gnt", 32'(rr.M_AXI_ARVALID), 1);
          end
        end
        if (rr.F_RVALID || rr.D_RVALID) begin
          if (rr_rsp_q.size() == 0) checkOutput("rr_rvalid_unexpected", 32'(rr.F_RVALID | rr.D_RVALID), 0);
          else begin
            r = rr_rsp_q.pop_front();
            checkOutput("rr_rsp_owner", 32'(rr.D_RVALID), 32'(r.owner));
            checkOutput("rr_rsp_both", 32'(rr.F_RVALID & rr.D_RVALID), 0);
            checkOutput("rr_rdata", r.owner ? rr.D_RDATA : rr.F_RDATA, r.data);
            checkOutput("rr_rerr", 32'(r.owner ? rr.D_RERR : rr.F_RERR), 32'(r.err));
          end
        end
      end
    end
  end

  // Monitor for the fp instance
  initial begin : fp_monitor
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fp.F_GNT || fp.D_GNT) begin
          if (fp_gnt_q.size() == 0) checkOutput("fp_gnt_unexpected", 32'(fp.F_GNT | fp.D_GNT), 0);
          else begin
            g = fp_gnt_q.pop_front();
            checkOutput("fp_gnt_owner", 32'(fp.D_GNT), 32'(g.owner));
            checkOutput("fp_arid", 32'(fp.M_AXI_ARID), 32'(g.owner));
            checkOutput("fp_araddr", fp.M_AXI_ARADDR, g.addr);
          end
        end
        if (fp.F_RVALID || fp.D_RVALID) begin
          if (fp_rsp_q.size() == 0) checkOutput("fp_rvalid_unexpected", 32'(fp.F_RVALID | fp.D_RVALID), 0);
          else begin
            r = fp_rsp_q.pop_front();
            checkOutput("fp_rsp_owner", 32'(fp.D_RVALID), 32'(r.owner));
            checkOutput("fp_rdata", r.owner ? fp.D_RDATA : fp.F_RDATA, r.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int lat, lat2, cyc, ng, nf;
    logic [31:0] last_f_data;

    rr.F_REQ = 0; rr.F_ADDR = '0; rr.D_REQ = 0; rr.D_ADDR = '0;
    rr.M_AXI_ARREADY = 0; rr.M_AXI_RVALID = 0; rr.M_AXI_RLAST = 0;
    rr.M_AXI_RDATA = '0; rr.M_AXI_RRESP = '0;
    fp.F_REQ = 0; fp.F_ADDR = '0; fp.D_REQ = 0; fp.D_ADDR = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_arvalid", 32'(rr.M_AXI_ARVALID), 0);
    checkOutput("rst_rready", 32'(rr.M_AXI_RREADY), 0);
    checkOutput("rst_busy", 32'(rr.BUSY), 0);
    checkOutput("rst_gnt", 32'({rr.F_GNT, rr.D_GNT}), 0);
    checkOutput("rst_rvalid", 32'({rr.F_RVALID, rr.D_RVALID}), 0);
    checkOutput("rst_f_rdata", rr.F_RDATA, 0);
    checkOutput("rst_d_rdata", rr.D_RDATA, 0);
    checkOutput("rst_rerr", 32'({rr.F_RERR, rr.D_RERR}), 0);
    checkOutput("rst_araddr", rr.M_AXI_ARADDR, 0);
    checkOutput("rst_arid", 32'(rr.M_AXI_ARID), 0);
    checkOutput("const_arlen", 32'(rr.M_AXI_ARLEN), 0);
    checkOutput("const_arsize", 32'(rr.M_AXI_ARSIZE), 2);
    checkOutput("const_arburst", 32'(rr.M_AXI_ARBURST), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin tie from reset: F, D, F, D
    slv_ar_wait = 0; slv_r_wait = 0; slv_pre = 0;
    slv_data = 32'hCAFE_0000; slv_resp = 2'b00;
    for (int k = 0; k < 4; k++) begin
      rr_gnt_q.push_back(gnt_t'{owner: k[0], addr: k[0] ? 32'h300 : 32'h200});
      rr_rsp_q.push_back(rsp_t'{owner: k[0], data: 32'hCAFE_0000, err: 1'b0});
    end
    rr.F_ADDR = 32'h200; rr.D_ADDR = 32'h300;
    rr.F_REQ = 1'b1; rr.D_REQ = 1'b1;
    cyc = 0; ng = 0;
    while (ng < 4 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (rr.F_GNT || rr.D_GNT) ng++;
    end
    rr.F_REQ = 1'b0; rr.D_REQ = 1'b0;
    checkOutput("tie_grant_count", ng, 4);
    cyc = 0;
    while (rr_rsp_q.size() != 0 && cyc < 40) begin @(negedge clk); cyc++; end
    checkOutput("tie_drain", rr_rsp_q.size(), 0);
    @(negedge clk);

    // Fixed priority: F wins while it keeps asking
    for (int k = 0; k < 3; k++) begin
      fp_gnt_q.push_back(gnt_t'{owner: 1'b0, addr: 32'h400});
      fp_rsp_q.push_back(rsp_t'{owner: 1'b0, data: 32'hA5A5_0400, err: 1'b0});
    end
    fp_gnt_q.push_back(gnt_t'{owner: 1'b1, addr: 32'h500});
    fp_rsp_q.push_back(rsp_t'{owner: 1'b1, data: 32'hA5A5_0500, err: 1'b0});
    fp.F_ADDR = 32'h400; fp.D_ADDR = 32'h500;
    fp.F_REQ = 1'b1; fp.D_REQ = 1'b1;
    cyc = 0; nf = 0;
    while (nf < 3 && cyc < 80) begin
      @(negedge clk); cyc++;
      if (fp.F_GNT) nf++;
    end
    fp.F_REQ = 1'b0;
    checkOutput("fp_f_grants", nf, 3);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!fp.D_GNT && cyc < 20);
    fp.D_REQ = 1'b0;
    checkOutput("fp_d_granted", 32'(fp.D_GNT), 1);
    cyc = 0;
    while (fp_rsp_q.size() != 0 && cyc < 40) begin @(negedge clk); cyc++; end
    checkOutput("fp_drain", fp_rsp_q.size(), 0);

    // Single read with minimum latency
    applyStimulus(1'b0, 32'h100, 32'hDEAD_BEEF, 2'b00, 1'b1, lat);
    checkOutput("single_gnt_latency", lat, 1);
    checkOutput("single_busy", 32'(rr.BUSY), 1);
    waitResponse(lat2);
    checkOutput("single_rsp_latency", lat2, 2);
    @(negedge clk);
    checkOutput("single_rvalid_pulse", 32'({rr.F_RVALID, rr.D_RVALID}), 0);
    checkOutput("single_busy_idle", 32'(rr.BUSY), 0);

    // Backpressure: ARREADY withheld 5 cycles, RVALID delayed 7
    slv_ar_wait = 5; slv_r_wait = 7;
    applyStimulus(1'b0, 32'h104, 32'h55AA_1234, 2'b00, 1'b1, lat);
    last_f_data = 32'h55AA_1234;
    checkOutput("bp_gnt_latency", lat, 1);
    for (int k = 0; k < 6; k++) begin
      checkOutput("bp_arvalid_held", 32'(rr.M_AXI_ARVALID), 1);
      checkOutput("bp_araddr_stable", rr.M_AXI_ARADDR, 32'h104);
      checkOutput("bp_busy_addr", 32'(rr.BUSY), 1);
      @(negedge clk);
    end
    checkOutput("bp_arvalid_dropped", 32'(rr.M_AXI_ARVALID), 0);
    cyc = 0;
    while (!(rr.F_RVALID || rr.D_RVALID) && cyc < 40) begin
      checkOutput("bp_rready_busy", 32'({rr.M_AXI_RREADY, rr.BUSY}), 3);
      @(negedge clk); cyc++;
    end
    checkOutput("bp_data_wait", cyc, 8);
    @(negedge clk);
    checkOutput("bp_single_pulse", 32'({rr.F_RVALID, rr.D_RVALID}), 0);
    slv_ar_wait = 0; slv_r_wait = 0;

    // Error response on D, with a discarded non-last beat in front
    slv_pre = 1; slv_pre_data = 32'hBAD0_BAD0; slv_pre_resp = 2'b00;
    applyStimulus(1'b1, 32'h380, 32'h1234_5678, 2'b10, 1'b1, lat);
    waitResponse(lat2);
    checkOutput("err_rsp_latency", lat2, 3);
    checkOutput("err_f_rdata_held", rr.F_RDATA, last_f_data);
    checkOutput("err_f_rerr_held", 32'(rr.F_RERR), 0);
    @(negedge clk);

    // An error on a dropped beat must not leak into the result
    slv_pre = 2; slv_pre_data = 32'hFFFF_FFFF; slv_pre_resp = 2'b10;
    applyStimulus(1'b1, 32'h384, 32'h0000_00FF, 2'b00, 1'b1, lat);
    waitResponse(lat2);
    checkOutput("multi_rsp_latency", lat2, 4);
    checkOutput("multi_f_rdata_held", rr.F_RDATA, last_f_data);
    slv_pre = 0;
    @(negedge clk);

    // Asynchronous reset while in ADDR
    slv_ar_wait = 20;
    applyStimulus(1'b0, 32'h180, 32'h1111_1111, 2'b00, 1'b0, lat);
    @(negedge clk);
    checkOutput("midrst_pre_arvalid", 32'(rr.M_AXI_ARVALID), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_arvalid", 32'(rr.M_AXI_ARVALID), 0);
    checkOutput("midrst_busy", 32'(rr.BUSY), 0);
    checkOutput("midrst_rready", 32'(rr.M_AXI_RREADY), 0);
    checkOutput("midrst_araddr", rr.M_AXI_ARADDR, 0);
    checkOutput("midrst_f_rdata", rr.F_RDATA, 0);
    checkOutput("midrst_d_rdata", rr.D_RDATA, 0);
    checkOutput("midrst_d_rerr", 32'(rr.D_RERR), 0);
    repeat (2) @(negedge clk);
    slv_ar_wait = 0;
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 32'h1C0, 32'h7777_8888, 2'b00, 1'b1, lat);
    checkOutput("postrst_gnt_latency", lat, 1);
    waitResponse(lat2);
    checkOutput("postrst_rsp_latency", lat2, 2);
    repeat (2) @(negedge clk);

    checkOutput("rr_gnt_q_empty", rr_gnt_q.size(), 0);
    checkOutput("rr_rsp_q_empty", rr_rsp_q.size(), 0);
    checkOutput("fp_gnt_q_empty", fp_gnt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
